// File: rtl/mips_multicycle_control.sv
// Main control FSM for a multicycle MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory and writeback.
// The datapath selects and write strobes are decoded from the current state.
// Memory states wait on mem_ready; a bounded wait counter raises bus_error when the memory stalls too long.
module mips_multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] ula_operation,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       bus_error
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [5:0]       opcode_q, opcode_d;
    logic             mem_wait;
    logic             timeout;
    logic             opcode_illegal;

    // ALU operation for an immediate-type instruction, from the opcode latched in DECODE
    function automatic logic [2:0] itype_ula(input logic [5:0] op);
        case (op)
            OP_SLTI: return 3'b011;
            OP_ANDI: return 3'b100;
            OP_ORI:  return 3'b101;
            OP_XORI: return 3'b110;
            OP_LUI:  return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Next-state, wait-counter and opcode-latch logic
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d        = state_q;
        opcode_d       = opcode_q;
        opcode_illegal = 1'b0;
        mem_wait       = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                          (state_q == S_MEM_WRITE)) && !mem_ready;
        timeout        = mem_wait && (wait_cnt_q == LIMIT);

        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                opcode_d = opcode;
                case (opcode)
                    OP_RTYPE:      state_d = S_R_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI: state_d = S_I_EXEC;
                    default: begin
                        state_d        = S_FETCH;
                        opcode_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (mem_ready || timeout) state_d = S_FETCH;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase

        // A timeout restarts the count even when FETCH loops back onto itself
        if ((state_d != state_q) || timeout) wait_cnt_d = '0;
        else if (mem_wait)                   wait_cnt_d = wait_cnt_q + 1'b1;
        else                                 wait_cnt_d = wait_cnt_q;
    end

    // State, wait counter and latched opcode registers with synchronous reset
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            opcode_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            opcode_q   <= opcode_d;
        end
    end

    // Datapath controls decoded from the current state, forced low while in reset
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        ula_operation = 3'b000;
        state         = state_q;
        illegal_op    = opcode_illegal;
        bus_error     = timeout;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:    alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a     = 1'b1;
                ula_operation = 3'b010;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                ula_operation = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_I_EXEC: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                ula_operation = itype_ula(opcode_q);
            end
            S_I_WB: begin
                reg_write     = 1'b1;
                ula_operation = itype_ula(opcode_q);
            end
            default: ;
        endcase

        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            pc_source     = 2'b00;
            ula_operation = 3'b000;
            state         = 4'd0;
            illegal_op    = 1'b0;
            bus_error     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: the driver pushes hand-computed per-cycle expectations,
// and the monitor pops and compares them on the falling edge.
module tb_mips_multicycle_control;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] ula_operation;
    logic [3:0] state;
    logic       illegal_op, bus_error;

    mips_multicycle_control #(.WAIT_LIMIT(3), .CNT_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .pc_source    (pc_source),
        .ula_operation(ula_operation),
        .state        (state),
        .illegal_op   (illegal_op),
        .bus_error    (bus_error)
    );

    always #5 clock = ~clock;

    // Single-bit control flags, packed MSB first as pc_write ... alu_src_a
    localparam logic [9:0] F_PCW  = 10'b10_0000_0000;
    localparam logic [9:0] F_PWC  = 10'b01_0000_0000;
    localparam logic [9:0] F_IOD  = 10'b00_1000_0000;
    localparam logic [9:0] F_MRD  = 10'b00_0100_0000;
    localparam logic [9:0] F_MWR  = 10'b00_0010_0000;
    localparam logic [9:0] F_IRW  = 10'b00_0001_0000;
    localparam logic [9:0] F_MTR  = 10'b00_0000_1000;
    localparam logic [9:0] F_RDST = 10'b00_0000_0100;
    localparam logic [9:0] F_RW   = 10'b00_0000_0010;
    localparam logic [9:0] F_SRCA = 10'b00_0000_0001;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [9:0] fl;
        logic [1:0] sb;
        logic [1:0] ps;
        logic [2:0] ula;
        logic       ill;
        logic       be;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [22:0] got, input logic [22:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got fl=%b sb=%b ps=%b ula=%b st=%0d ill=%b be=%b, expected fl=%b sb=%b ps=%b ula=%b st=%0d ill=%b be=%b",
                     name, got[22:13], got[12:11], got[10:9], got[8:6], got[5:2], got[1], got[0],
                     want[22:13], want[12:11], want[10:9], want[8:6], want[5:2], want[1], want[0]);
        end
    endtask

    // Monitor: every cycle the DUT presents its control word; compare against the oldest expectation
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                exp_t e;
                logic [22:0] got, want;
                e    = exp_q.pop_front();
                got  = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                        mem_to_reg, reg_dst, reg_write, alu_src_a,
                        alu_src_b, pc_source, ula_operation, state, illegal_op, bus_error};
                want = {e.fl, e.sb, e.ps, e.ula, e.st, e.ill, e.be};
                check(e.name, got, want);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue what that cycle must show
    task automatic step(input string name, input logic rst, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic [9:0] fl, input logic [1:0] sb,
                        input logic [1:0] ps, input logic [2:0] ula, input logic ill, input logic be);
        exp_t e;
        @(posedge clock);
        #1;
        reset     = rst;
        opcode    = op;
        mem_ready = rdy;
        e.name = name; e.st = st; e.fl = fl; e.sb = sb; e.ps = ps;
        e.ula = ula; e.ill = ill; e.be = be;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input string name, input logic [5:0] op);
        step(name, 1'b0, op, 1'b1, 4'd0, F_PCW | F_MRD | F_IRW, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic decode(input string name, input logic [5:0] op);
        step(name, 1'b0, op, 1'b1, 4'd1, 10'd0, 2'b11, 2'b00, 3'b000, 1'b0, 1'b0);
    endtask

    typedef struct { logic [5:0] op; logic [2:0] ula; } itype_t;
    itype_t itab[5] = '{'{6'b001000, 3'b000}, '{6'b001010, 3'b011}, '{6'b001100, 3'b100},
                        '{6'b001101, 3'b101}, '{6'b001111, 3'b111}};

    initial begin
        // Reset held three cycles: everything low
        for (int i = 0; i < 3; i++)
            step("reset", 1'b1, 6'd0, 1'b1, 4'd0, 10'd0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);

        // R-type: 0,1,6,7
        fetch("r_fetch", 6'b000000);
        decode("r_decode", 6'b000000);
        step("r_exec", 1'b0, 6'b000000, 1'b1, 4'd6, F_SRCA, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0);
        step("r_wb", 1'b0, 6'b000000, 1'b1, 4'd7, F_RW | F_RDST, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);

        // lw with two stall cycles in MEM_READ: 0,1,2,3,3,3,4
        fetch("lw_fetch", 6'b100011);
        decode("lw_decode", 6'b100011);
        step("lw_addr", 1'b0, 6'b100011, 1'b1, 4'd2, F_SRCA, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
        step("lw_rd_wait1", 1'b0, 6'b100011, 1'b0, 4'd3, F_MRD | F_IOD, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        step("lw_rd_wait2", 1'b0, 6'b100011, 1'b0, 4'd3, F_MRD | F_IOD, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        step("lw_rd_done", 1'b0, 6'b100011, 1'b1, 4'd3, F_MRD | F_IOD, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        step("lw_wb", 1'b0, 6'b100011, 1'b1, 4'd4, F_RW | F_MTR, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);

        // sw, opcode bus changes after DECODE: still goes to MEM_WRITE
        fetch("sw_fetch", 6'b101011);
        decode("sw_decode", 6'b101011);
        step("sw_addr", 1'b0, 6'b000000, 1'b1, 4'd2, F_SRCA, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
        step("sw_write", 1'b0, 6'b000000, 1'b1, 4'd5, F_MWR | F_IOD, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);

        // beq and j
        fetch("beq_fetch", 6'b000100);
        decode("beq_decode", 6'b000100);
        step("beq_branch", 1'b0, 6'b000100, 1'b1, 4'd8, F_SRCA | F_PWC, 2'b00, 2'b01, 3'b001, 1'b0, 1'b0);
        fetch("j_fetch", 6'b000010);
        decode("j_decode", 6'b000010);
        step("j_jump", 1'b0, 6'b000010, 1'b1, 4'd9, F_PCW, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);

        // xori with the opcode bus changed to 000000 after DECODE
        fetch("xori_fetch", 6'b001110);
        decode("xori_decode", 6'b001110);
        step("xori_exec", 1'b0, 6'b000000, 1'b1, 4'd10, F_SRCA, 2'b10, 2'b00, 3'b110, 1'b0, 1'b0);
        step("xori_wb", 1'b0, 6'b000000, 1'b1, 4'd11, F_RW, 2'b00, 2'b00, 3'b110, 1'b0, 1'b0);

        // Remaining immediate ops
        for (int i = 0; i < 5; i++) begin
            fetch("itype_fetch", itab[i].op);
            decode("itype_decode", itab[i].op);
            step("itype_exec", 1'b0, itab[i].op, 1'b1, 4'd10, F_SRCA, 2'b10, 2'b00, itab[i].ula, 1'b0, 1'b0);
            step("itype_wb", 1'b0, itab[i].op, 1'b1, 4'd11, F_RW, 2'b00, 2'b00, itab[i].ula, 1'b0, 1'b0);
        end

        // Undefined opcodes: one-cycle illegal_op in DECODE, then FETCH
        fetch("ill_fetch", 6'b111111);
        step("ill_decode", 1'b0, 6'b111111, 1'b1, 4'd1, 10'd0, 2'b11, 2'b00, 3'b000, 1'b1, 1'b0);
        fetch("ill_refetch", 6'b000011);
        step("ill_decode2", 1'b0, 6'b000011, 1'b1, 4'd1, 10'd0, 2'b11, 2'b00, 3'b000, 1'b1, 1'b0);

        // FETCH timeout: bus_error on the 4th waiting cycle, no ir_write
        for (int i = 0; i < 3; i++)
            step("fetch_wait", 1'b0, 6'b000010, 1'b0, 4'd0, F_MRD, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0);
        step("fetch_timeout", 1'b0, 6'b000010, 1'b0, 4'd0, F_MRD, 2'b01, 2'b00, 3'b000, 1'b0, 1'b1);
        // Counter restarted: three more waits without error, completion on the limit cycle wins
        for (int i = 0; i < 3; i++)
            step("fetch_rewait", 1'b0, 6'b000010, 1'b0, 4'd0, F_MRD, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0);
        fetch("fetch_limit_ready", 6'b000010);
        decode("fetch_limit_decode", 6'b000010);
        step("fetch_limit_jump", 1'b0, 6'b000010, 1'b1, 4'd9, F_PCW, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);

        // MEM_READ timeout: error on the 4th wait, back to FETCH without MEM_WB
        fetch("lwto_fetch", 6'b100011);
        decode("lwto_decode", 6'b100011);
        step("lwto_addr", 1'b0, 6'b100011, 1'b1, 4'd2, F_SRCA, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("lwto_wait", 1'b0, 6'b100011, 1'b0, 4'd3, F_MRD | F_IOD, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        step("lwto_timeout", 1'b0, 6'b100011, 1'b0, 4'd3, F_MRD | F_IOD, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
        fetch("lwto_refetch", 6'b000000);

        // Reset mid-instruction: abandoned, restart at FETCH
        decode("rst_mid_decode", 6'b000000);
        step("rst_mid", 1'b1, 6'b000000, 1'b1, 4'd0, 10'd0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
        fetch("rst_release", 6'b000000);
        decode("rst_decode", 6'b000000);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
